// File: rtl/hazard_ctrl_pipe.sv
// Hazard control and ID/EX, EX/MEM, MEM/WB control pipeline for a 5-stage integer core.
// Detects load-use (or, without forwarding, any RAW) hazards against the ID instruction and
// selects ALU operand forwarding sources for the EX stage.
// Build option: HAZARD_FORWARDING_EN enables EX/MEM and MEM/WB forwarding; when it is undefined,
// fwd_a/fwd_b stay 00 and every RAW hazard on an EX or MEM producer stalls.
module hazard_ctrl_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dst,
  input  logic       id_alu_src,
  input  logic       id_mem_read,
  input  logic       id_mem_write,
  input  logic       id_reg_write,
  input  logic [1:0] id_reg_data,
  input  logic [2:0] id_alu_opc,
  output logic       stall,
  output logic       ex_alu_src,
  output logic       ex_mem_read,
  output logic       ex_mem_write,
  output logic       ex_reg_write,
  output logic [1:0] ex_reg_data,
  output logic [2:0] ex_alu_opc,
  output logic [4:0] ex_rs,
  output logic [4:0] ex_rt,
  output logic [4:0] ex_dst,
  output logic       mem_mem_read,
  output logic       mem_mem_write,
  output logic       mem_reg_write,
  output logic [1:0] mem_reg_data,
  output logic [4:0] mem_dst,
  output logic       wb_reg_write,
  output logic [1:0] wb_reg_data,
  output logic [4:0] wb_dst,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef struct packed {
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_data;
    logic [2:0] alu_opc;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
  } idex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_data;
    logic [4:0] dst;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] reg_data;
    logic [4:0] dst;
  } memwb_t;

  idex_t  idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  // A producer hits a used source only if it writes a nonzero register equal to that source.
  function automatic logic src_hit(input logic wr, input logic [4:0] dst, input logic [4:0] src,
                                   input logic used);
    return used && wr && (dst != 5'd0) && (dst == src);
  endfunction

  logic ex_hit;
  assign ex_hit = src_hit(idex_q.reg_write, idex_q.dst, id_rs, id_uses_rs) |
                  src_hit(idex_q.reg_write, idex_q.dst, id_rt, id_uses_rt);

`ifdef HAZARD_FORWARDING_EN
  // EX/MEM is checked first so the younger producer wins.
  function automatic logic [1:0] fwd_sel(input exmem_t m, input memwb_t w, input logic [4:0] src);
    if (m.reg_write && (m.dst != 5'd0) && (m.dst == src)) return 2'b10;
    if (w.reg_write && (w.dst != 5'd0) && (w.dst == src)) return 2'b01;
    return 2'b00;
  endfunction

  // Only a load in EX cannot be forwarded in time.
  always_comb begin
    stall = idex_q.mem_read & ex_hit;
    fwd_a = fwd_sel(exmem_q, memwb_q, idex_q.rs);
    fwd_b = fwd_sel(exmem_q, memwb_q, idex_q.rt);
  end
`else
  logic mem_hit;
  assign mem_hit = src_hit(exmem_q.reg_write, exmem_q.dst, id_rs, id_uses_rs) |
                   src_hit(exmem_q.reg_write, exmem_q.dst, id_rt, id_uses_rt);

  // No bypass paths: wait until the producer reaches WB (register file writes before read).
  always_comb begin
    stall = ex_hit | mem_hit;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
  end
`endif

  // Next-state: ID/EX takes a bubble on stall, later stages always advance.
  always_comb begin
    idex_d  = '{alu_src: id_alu_src, mem_read: id_mem_read, mem_write: id_mem_write,
                reg_write: id_reg_write, reg_data: id_reg_data, alu_opc: id_alu_opc,
                rs: id_rs, rt: id_rt, dst: id_dst};
    if (stall) idex_d = '0;
    exmem_d = '{mem_read: idex_q.mem_read, mem_write: idex_q.mem_write,
                reg_write: idex_q.reg_write, reg_data: idex_q.reg_data, dst: idex_q.dst};
    memwb_d = '{reg_write: exmem_q.reg_write, reg_data: exmem_q.reg_data, dst: exmem_q.dst};
  end

  // Pipeline registers; synchronous reset overrides stall and advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_alu_src    = idex_q.alu_src;
  assign ex_mem_read   = idex_q.mem_read;
  assign ex_mem_write  = idex_q.mem_write;
  assign ex_reg_write  = idex_q.reg_write;
  assign ex_reg_data   = idex_q.reg_data;
  assign ex_alu_opc    = idex_q.alu_opc;
  assign ex_rs         = idex_q.rs;
  assign ex_rt         = idex_q.rt;
  assign ex_dst        = idex_q.dst;
  assign mem_mem_read  = exmem_q.mem_read;
  assign mem_mem_write = exmem_q.mem_write;
  assign mem_reg_write = exmem_q.reg_write;
  assign mem_reg_data  = exmem_q.reg_data;
  assign mem_dst       = exmem_q.dst;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_reg_data   = memwb_q.reg_data;
  assign wb_dst        = memwb_q.dst;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: a per-cycle reference of the pipeline contents, stall and
// forwarding selects, plus directed instruction sequences with hand-derived expectations.
module tb_hazard_ctrl_pipe;

  typedef struct packed {
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_data;
    logic [2:0] alu_opc;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
  } ins_t;

`ifdef HAZARD_FORWARDING_EN
  localparam int RAW1_ST = 0;  // back-to-back RAW
  localparam int LU_REST = 0;  // load-use stalls after the first one
  localparam int GAP_ST  = 0;  // RAW with one instruction between
  localparam logic [1:0] RAW1_FA = 2'b10;
  localparam logic [1:0] LU_FB   = 2'b01;
  localparam logic [1:0] GAP_F   = 2'b01;
`else
  localparam int RAW1_ST = 2;
  localparam int LU_REST = 1;
  localparam int GAP_ST  = 1;
  localparam logic [1:0] RAW1_FA = 2'b00;
  localparam logic [1:0] LU_FB   = 2'b00;
  localparam logic [1:0] GAP_F   = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic       id_alu_src = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0, id_reg_write = 1'b0;
  logic [1:0] id_reg_data = '0;
  logic [2:0] id_alu_opc = '0;
  logic       stall;
  logic       ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [1:0] ex_reg_data;
  logic [2:0] ex_alu_opc;
  logic [4:0] ex_rs, ex_rt, ex_dst;
  logic       mem_mem_read, mem_mem_write, mem_reg_write;
  logic [1:0] mem_reg_data;
  logic [4:0] mem_dst;
  logic       wb_reg_write;
  logic [1:0] wb_reg_data;
  logic [4:0] wb_dst;
  logic [1:0] fwd_a, fwd_b;

  hazard_ctrl_pipe dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_reg_data(id_reg_data), .id_alu_opc(id_alu_opc), .stall(stall),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_reg_data(ex_reg_data), .ex_alu_opc(ex_alu_opc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
    .mem_reg_data(mem_reg_data), .mem_dst(mem_dst), .wb_reg_write(wb_reg_write),
    .wb_reg_data(wb_reg_data), .wb_dst(wb_dst), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: m_pipe[0]=EX, [1]=MEM, [2]=WB instruction records.
  ins_t m_pipe[3];
  ins_t id_ins;
  logic m_stall;

  function automatic logic hit(input ins_t p, input logic [4:0] r, input logic u);
    return u && p.reg_write && (p.dst != 5'd0) && (p.dst == r);
  endfunction

`ifdef HAZARD_FORWARDING_EN
  function automatic logic [1:0] fsel(input ins_t m, input ins_t w, input logic [4:0] r);
    if (m.reg_write && m.dst != 5'd0 && m.dst == r) return 2'b10;
    if (w.reg_write && w.dst != 5'd0 && w.dst == r) return 2'b01;
    return 2'b00;
  endfunction
`endif

  always_comb begin
    id_ins  = {id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_reg_data, id_alu_opc,
               id_rs, id_rt, id_dst};
    m_stall = 1'b0;
`ifdef HAZARD_FORWARDING_EN
    if (m_pipe[0].mem_read &&
        (hit(m_pipe[0], id_rs, id_uses_rs) || hit(m_pipe[0], id_rt, id_uses_rt)))
      m_stall = 1'b1;
`else
    for (int s = 0; s < 2; s++)
      if (hit(m_pipe[s], id_rs, id_uses_rs) || hit(m_pipe[s], id_rt, id_uses_rt))
        m_stall = 1'b1;
`endif
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 3; s++) m_pipe[s] <= '0;
    end else begin
      for (int s = 1; s < 3; s++) m_pipe[s] <= m_pipe[s-1];
      m_pipe[0] <= m_stall ? '0 : id_ins;
    end
  end

  logic [1:0] e_a, e_b;
  always_comb begin
`ifdef HAZARD_FORWARDING_EN
    e_a = fsel(m_pipe[1], m_pipe[2], m_pipe[0].rs);
    e_b = fsel(m_pipe[1], m_pipe[2], m_pipe[0].rt);
`else
    e_a = 2'b00;
    e_b = 2'b00;
`endif
  end

  ins_t dut_ex;
  assign dut_ex = {ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_reg_data, ex_alu_opc,
                   ex_rs, ex_rt, ex_dst};

  // Per-cycle comparison against the reference on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(m_stall));
      check("fwd_a", 32'(fwd_a), 32'(e_a));
      check("fwd_b", 32'(fwd_b), 32'(e_b));
      check("id_ex", 32'(dut_ex), 32'(m_pipe[0]));
      check("ex_mem", 32'({mem_mem_read, mem_mem_write, mem_reg_write, mem_reg_data, mem_dst}),
            32'({m_pipe[1].mem_read, m_pipe[1].mem_write, m_pipe[1].reg_write,
                 m_pipe[1].reg_data, m_pipe[1].dst}));
      check("mem_wb", 32'({wb_reg_write, wb_reg_data, wb_dst}),
            32'({m_pipe[2].reg_write, m_pipe[2].reg_data, m_pipe[2].dst}));
    end
  end

  function automatic ins_t mk(input logic as, mr, mw, rw, input logic [1:0] rd,
                              input logic [2:0] opc, input logic [4:0] rs, rt, dst);
    return {as, mr, mw, rw, rd, opc, rs, rt, dst};
  endfunction

  task automatic drive(input ins_t i, input logic ur, input logic ut);
    {id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_reg_data, id_alu_opc,
     id_rs, id_rt, id_dst} = i;
    id_uses_rs = ur;
    id_uses_rt = ut;
  endtask

  // Present an instruction in ID, hold it while the reference stalls; returns stall cycles.
  task automatic issue(input ins_t i, input logic ur, input logic ut, output int nst);
    logic st;
    drive(i, ur, ut);
    nst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      st = m_stall;
      @(posedge clk);
      #1;
      if (!st) break;
      nst++;
    end
  endtask

  task automatic flush();
    int n;
    for (int k = 0; k < 3; k++) issue('0, 1'b0, 1'b0, n);
  endtask

  logic [31:0] all_out;
  assign all_out = 32'({stall, fwd_a, fwd_b, dut_ex, mem_mem_read, mem_mem_write,
                        mem_reg_write, mem_reg_data, mem_dst, wb_reg_write, wb_reg_data, wb_dst}
                       != '0);

  initial begin
    int n;
    ins_t add3, sub3, lw5, add5, addi0, lw0, use0, p7a, p7b, c7, p10, mid, c10, sw;
    add3  = mk(0, 0, 0, 1, 2'b00, 3'd2, 5'd1, 5'd2, 5'd3);
    sub3  = mk(0, 0, 0, 1, 2'b00, 3'd6, 5'd3, 5'd4, 5'd5);
    lw5   = mk(1, 1, 0, 1, 2'b01, 3'd2, 5'd1, 5'd0, 5'd5);
    add5  = mk(0, 0, 0, 1, 2'b00, 3'd2, 5'd6, 5'd5, 5'd8);
    addi0 = mk(1, 0, 0, 1, 2'b00, 3'd2, 5'd1, 5'd0, 5'd0);
    lw0   = mk(1, 1, 0, 1, 2'b01, 3'd2, 5'd2, 5'd0, 5'd0);
    use0  = mk(0, 0, 0, 1, 2'b00, 3'd2, 5'd0, 5'd0, 5'd11);
    p7a   = mk(0, 0, 0, 1, 2'b00, 3'd2, 5'd1, 5'd2, 5'd7);
    p7b   = mk(0, 0, 0, 1, 2'b00, 3'd0, 5'd3, 5'd4, 5'd7);
    c7    = mk(0, 0, 0, 1, 2'b00, 3'd2, 5'd7, 5'd9, 5'd12);
    p10   = mk(0, 0, 0, 1, 2'b10, 3'd7, 5'd1, 5'd2, 5'd10);
    mid   = mk(0, 0, 0, 1, 2'b00, 3'd1, 5'd13, 5'd14, 5'd15);
    c10   = mk(0, 0, 0, 1, 2'b00, 3'd2, 5'd10, 5'd10, 5'd16);
    sw    = mk(1, 0, 1, 0, 2'b00, 3'd2, 5'd2, 5'd3, 5'd0);

    drive(p7a, 1'b1, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_zero", all_out, 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    drive('0, 1'b0, 1'b0);
    chk_en = 1'b1;

    // Back-to-back RAW on $3.
    issue(add3, 1'b1, 1'b1, n);
    check("raw1_producer_stall", 32'(n), 32'd0);
    issue(sub3, 1'b1, 1'b1, n);
    check("raw1_stall_cycles", 32'(n), 32'(RAW1_ST));
    check("raw1_fwd_a", 32'(fwd_a), 32'(RAW1_FA));
    check("raw1_ex_rs", 32'(ex_rs), 32'd3);
    issue(sw, 1'b1, 1'b1, n);
    flush();

    // Load-use on $5 via rt.
    issue(lw5, 1'b1, 1'b0, n);
    drive(add5, 1'b1, 1'b1);
    @(negedge clk);
    check("lu_stall_first", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    check("lu_bubble", 32'(dut_ex), 32'd0);
    check("lu_mem_is_load", 32'({mem_mem_read, mem_dst}), 32'({1'b1, 5'd5}));
    issue(add5, 1'b1, 1'b1, n);
    check("lu_rest_stalls", 32'(n), 32'(LU_REST));
    check("lu_fwd_b", 32'(fwd_b), 32'(LU_FB));
    flush();

    // Producers of $0 never stall or forward.
    issue(addi0, 1'b1, 1'b0, n);
    check("r0_addi_stall", 32'(n), 32'd0);
    issue(lw0, 1'b1, 1'b0, n);
    check("r0_lw_stall", 32'(n), 32'd0);
    issue(use0, 1'b1, 1'b1, n);
    check("r0_use_stall", 32'(n), 32'd0);
    check("r0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    flush();

    // Two producers of $7; the younger one must win.
    issue(p7a, 1'b1, 1'b1, n);
    issue(p7b, 1'b1, 1'b1, n);
    check("p7b_stall", 32'(n), 32'd0);
    issue(c7, 1'b1, 1'b1, n);
    check("p7_stall_cycles", 32'(n), 32'(RAW1_ST));
    check("p7_fwd_a", 32'(fwd_a), 32'(RAW1_FA));
    flush();

    // One independent instruction between producer and consumer of $10.
    issue(p10, 1'b1, 1'b1, n);
    issue(mid, 1'b1, 1'b1, n);
    issue(c10, 1'b1, 1'b1, n);
    check("gap_stall_cycles", 32'(n), 32'(GAP_ST));
    check("gap_fwd", 32'({fwd_a, fwd_b}), 32'({GAP_F, GAP_F}));
    flush();

    // Reset in the middle of a load-use stall.
    issue(lw5, 1'b1, 1'b0, n);
    drive(add5, 1'b1, 1'b1);
    @(negedge clk);
    check("rst_mid_stall_seen", 32'(stall), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outputs_zero", all_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_no_residual", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_consumer_in_ex", 32'(dut_ex), 32'(add5));
    flush();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
